// File: rtl/countdown_timer_ctrl.sv
// Sequencing controller for the MM:SS BCD countdown chain: step tick, preload line, button FSM, expiry.
// Optional expiry alarm enabled by defining COUNTDOWN_ALARM_EN.
`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif
`ifndef BCD_ZERO
`define BCD_ZERO 4'd0
`endif

module countdown_timer_ctrl #(
   parameter int TICK_DIV    = 100_000_000,
   parameter int ALARM_TICKS = 5
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      pause,
   input  logic                      clear,
   input  logic [`BCD_BIT_WIDTH-1:0] min_tens,
   input  logic [`BCD_BIT_WIDTH-1:0] min_ones,
   input  logic [`BCD_BIT_WIDTH-1:0] sec_tens,
   input  logic [`BCD_BIT_WIDTH-1:0] sec_ones,
   output logic                      decrease,
   output logic                      stop,
   output logic                      running,
   output logic                      done,
   output logic                      alarm
);

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

   state_t        state;
   logic [PW-1:0] prescaler;
   logic          zero;
   logic          wrap;

   assign zero = (min_tens == `BCD_ZERO) && (min_ones == `BCD_ZERO) &&
                 (sec_tens == `BCD_ZERO) && (sec_ones == `BCD_ZERO);
   assign wrap = (prescaler == LAST);

   assign stop    = (state == IDLE);
   assign running = (state == RUN);
   assign done    = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         prescaler <= '0;
         decrease  <= 1'b0;
      end else begin
         decrease <= 1'b0;
         if (clear) begin
            state     <= IDLE;
            prescaler <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     state     <= zero ? DONE : RUN;
                     prescaler <= '0;
                  end
               end
               RUN: begin
                  if (pause) begin
                     state <= PAUSE;
                  end else if (zero) begin
                     // never step past 00:00; prescaler restarts so alarm periods are whole
                     state     <= DONE;
                     prescaler <= '0;
                  end else begin
                     prescaler <= wrap ? '0 : prescaler + 1'b1;
                     decrease  <= wrap;
                  end
               end
               PAUSE: begin
                  if (start) state <= RUN;
               end
               DONE: begin
                  prescaler <= wrap ? '0 : prescaler + 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef COUNTDOWN_ALARM_EN
   localparam int AW = (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS) : 1;

   logic [AW-1:0] alarm_cnt;
   logic          enter_done;

   assign enter_done = !clear &&
                       (((state == IDLE) && start && zero) ||
                        ((state == RUN) && !pause && zero));

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         alarm     <= 1'b0;
         alarm_cnt <= '0;
      end else if (enter_done) begin
         alarm     <= 1'b1;
         alarm_cnt <= '0;
      end else if (alarm && (state == DONE) && wrap) begin
         if (alarm_cnt == AW'(ALARM_TICKS - 1)) alarm <= 1'b0;
         else                                   alarm_cnt <= alarm_cnt + 1'b1;
      end
   end
`else
   assign alarm = 1'b0;
`endif

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Bench for countdown_timer_ctrl: BCD chain model attached, per-cycle behavioural model plus directed literal checks.
`ifndef BCD_BIT_WIDTH
`define BCD_BIT_WIDTH 4
`endif

module tb_countdown_timer_ctrl;

   localparam int TD = 4;
   localparam int AT = 2;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic [`BCD_BIT_WIDTH-1:0] min_tens, min_ones, sec_tens, sec_ones;
   logic decrease, stop, running, done, alarm;

   int preset_s = 3;
   int cur_s = 0;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   countdown_timer_ctrl #(.TICK_DIV(TD), .ALARM_TICKS(AT)) dut (
      .clk(clk), .rst(rst), .start(start), .pause(pause), .clear(clear),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
      .decrease(decrease), .stop(stop), .running(running), .done(done), .alarm(alarm)
   );

   // counter chain: whole seconds, shown as MM:SS digits
   assign min_tens = `BCD_BIT_WIDTH'((cur_s / 60) / 10);
   assign min_ones = `BCD_BIT_WIDTH'((cur_s / 60) % 10);
   assign sec_tens = `BCD_BIT_WIDTH'((cur_s % 60) / 10);
   assign sec_ones = `BCD_BIT_WIDTH'((cur_s % 60) % 10);

   always @(posedge clk) begin
      if (stop === 1'b1)          cur_s <= preset_s;
      else if (decrease === 1'b1) cur_s <= (cur_s == 0) ? 3599 : cur_s - 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // behavioural model: mode plus cycles spent counting since start
   int cyc = 0, m_mode = M_IDLE, run_cyc = 0, done_at = 0;
   bit m_dec = 0, m_alarm = 0, mvalid = 0;

   always @(posedge clk) begin
      logic s, p, c, r, z;
      s = start; p = pause; c = clear; r = rst; z = (cur_s == 0);
      #1;
      cyc++;
      m_dec = 0;
      if (r) begin
         mvalid = 1;
         m_mode = M_IDLE;
      end else if (c) begin
         m_mode = M_IDLE;
      end else begin
         case (m_mode)
            M_IDLE:
               if (s) begin
                  if (z) begin m_mode = M_DONE; done_at = cyc; end
                  else   begin m_mode = M_RUN;  run_cyc = 0;   end
               end
            M_RUN:
               if (p) m_mode = M_PAUSE;
               else if (z) begin m_mode = M_DONE; done_at = cyc; end
               else begin
                  m_dec = ((run_cyc + 1) % TD == 0);
                  run_cyc++;
               end
            M_PAUSE: if (s) m_mode = M_RUN;
            default: ;
         endcase
      end
`ifdef COUNTDOWN_ALARM_EN
      m_alarm = (m_mode == M_DONE) && (cyc - done_at < AT * TD);
`else
      m_alarm = 0;
`endif
      if (mvalid) begin
         chk("model_decrease", decrease, m_dec);
         chk("model_stop",     stop,     m_mode == M_IDLE);
         chk("model_running",  running,  m_mode == M_RUN);
         chk("model_done",     done,     m_mode == M_DONE);
         chk("model_alarm",    alarm,    m_alarm);
      end
   end

   task automatic pulse(input logic s, input logic p, input logic c);
      start = s; pause = p; clear = c;
      @(negedge clk);
      start = 1'b0; pause = 1'b0; clear = 1'b0;
   endtask

   task automatic wait_dec(input string name, input int bound);
      logic got;
      got = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (decrease === 1'b1) begin got = 1'b1; break; end
      end
      chk(name, got, 1);
   endtask

   initial begin
      int first, npulse, dpos, na, nd;
      repeat (2) @(negedge clk);
      chk("rst_stop", stop, 1);
      chk("rst_decrease", decrease, 0);
      chk("rst_running", running, 0);
      chk("rst_done", done, 0);
      chk("rst_alarm", alarm, 0);
      rst = 1'b0;

      // 00:03 runs down with one step every TD cycles
      preset_s = 3;
      repeat (2) @(negedge clk);
      pulse(1, 0, 0);
      first = -1; npulse = 0; dpos = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (decrease === 1'b1) begin npulse++; if (first < 0) first = i; end
         if (done === 1'b1 && dpos < 0) dpos = i;
      end
      chk("t1_first_dec", first, 4);
      chk("t1_pulses", npulse, 3);
      chk("t1_done_at", dpos, 14);
      chk("t1_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0000);

      // 01:00 borrows to 00:59
      pulse(0, 0, 1);
      preset_s = 60;
      repeat (2) @(negedge clk);
      pulse(1, 0, 0);
      wait_dec("t2_dec_seen", 10);
      @(negedge clk);
      chk("t2_digits", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0059);
      chk("t2_running", running, 1);
      chk("t2_stop", stop, 0);

      // pause with prescaler at 2, resume completes the step in 2 cycles
      @(negedge clk);
      pulse(0, 1, 0);
      npulse = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (decrease === 1'b1) npulse++;
      end
      chk("t3_pause_nodec", npulse, 0);
      chk("t3_pause_running", running, 0);
      chk("t3_pause_stop", stop, 0);
      pulse(1, 0, 0);
      first = -1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         if (decrease === 1'b1 && first < 0) first = i;
      end
      chk("t3_resume_dec", first, 2);

      // start at 00:00 goes straight to DONE
      pulse(0, 0, 1);
      chk("t4_clear_stop", stop, 1);
      preset_s = 0;
      repeat (2) @(negedge clk);
      pulse(1, 0, 0);
      chk("t4_done", done, 1);
      na = int'(alarm === 1'b1); nd = int'(decrease === 1'b1);
      for (int i = 1; i < 12; i++) begin
         @(negedge clk);
         na += int'(alarm === 1'b1);
         nd += int'(decrease === 1'b1);
      end
`ifdef COUNTDOWN_ALARM_EN
      chk("t6_alarm_cycles", na, 8);
`else
      chk("t6_alarm_cycles", na, 0);
`endif
      chk("t4_no_dec", nd, 0);
      pulse(0, 0, 1);
      chk("t4_idle_stop", stop, 1);
      chk("t4_idle_done", done, 0);
      chk("t4_idle_alarm", alarm, 0);

      // combined pulses and reset mid-run
      preset_s = 10;
      repeat (2) @(negedge clk);
      pulse(1, 1, 0);
      chk("t5_idle_sp_run", running, 1);
      repeat (2) @(negedge clk);
      pulse(1, 1, 0);
      chk("t5_run_sp_pause", running, 0);
      chk("t5_pause_stop", stop, 0);
      pulse(1, 1, 0);
      chk("t5_pause_sp_run", running, 1);
      pulse(1, 1, 1);
      chk("t5_clear_stop", stop, 1);
      chk("t5_clear_running", running, 0);
      pulse(1, 0, 0);
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("t5_rst_stop", stop, 1);
      chk("t5_rst_running", running, 0);
      chk("t5_rst_done", done, 0);
      chk("t5_rst_dec", decrease, 0);
      chk("t5_rst_alarm", alarm, 0);
      chk("t5_digits_before", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0009);
      @(negedge clk);
      chk("t5_digits_reload", {min_tens, min_ones, sec_tens, sec_ones}, 16'h0010);

      repeat (2) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
